// File: rtl/spr_pkg.sv
// rtl/spr_pkg.sv - shared types, LED codes and round judging for the match controller
package spr_pkg;

    typedef enum logic [1:0] {
        STONE    = 2'b00,
        PAPER    = 2'b01,
        SCISSORS = 2'b10,
        INVALID  = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        P1_WIN = 2'b00,
        DRAW   = 2'b01,
        P2_WIN = 2'b10,
        BAD    = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        WAIT_PRESS = 2'b00,
        JUDGE      = 2'b01,
        SHOW       = 2'b10,
        MATCH_DONE = 2'b11
    } state_t;

    localparam logic [2:0] LED_OFF  = 3'b000;
    localparam logic [2:0] LED_P1   = 3'b001;
    localparam logic [2:0] LED_DRAW = 3'b010;
    localparam logic [2:0] LED_P2   = 3'b100;
    localparam logic [2:0] LED_BAD  = 3'b111;

    // An invalid move on either side spoils the round before any comparison.
    function automatic result_t judge(move_t a, move_t b);
        result_t r;
        if (a == INVALID || b == INVALID) begin
            r = BAD;
        end else if (a == b) begin
            r = DRAW;
        end else if ((a == STONE    && b == SCISSORS) ||
                     (a == SCISSORS && b == PAPER)    ||
                     (a == PAPER    && b == STONE)) begin
            r = P1_WIN;
        end else begin
            r = P2_WIN;
        end
        return r;
    endfunction

endpackage

// File: rtl/spr_debounce.sv
// rtl/spr_debounce.sv - two-flop synchronizer plus stability counter for the play button
module spr_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    // The flip happens on the edge where the count would reach DEBOUNCE_CYCLES.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive samples that disagree with the current level; any agreement restarts.
    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/spr_match_ctrl.sv
// rtl/spr_match_ctrl.sv - best-of-N stone-paper-scissors match FSM, scoring and LED drive
module spr_match_ctrl
    import spr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int WIN_SCORE       = 3,
    localparam int SW             = $clog2(WIN_SCORE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    player1,
    input  logic [1:0]    player2,
    input  logic          btn_play,
    output logic [2:0]    leds,
    output logic [SW-1:0] p1_score,
    output logic [SW-1:0] p2_score,
    output logic          round_valid,
    output logic          match_over
);

    localparam logic [SW-1:0] WIN_SC = SW'(WIN_SCORE);

    logic btn_level;
    logic btn_press;

    spr_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst     (reset),
        .btn_raw (btn_play),
        .level   (btn_level),
        .press   (btn_press)
    );

    state_t        state_q, state_d;
    move_t         p1_move_q, p1_move_d;
    move_t         p2_move_q, p2_move_d;
    logic [2:0]    leds_q, leds_d;
    logic [SW-1:0] p1_score_q, p1_score_d;
    logic [SW-1:0] p2_score_q, p2_score_d;
    logic          round_valid_q, round_valid_d;

    // Next-state, move latching, judging and score updates.
    always_comb begin
        state_d       = state_q;
        p1_move_d     = p1_move_q;
        p2_move_d     = p2_move_q;
        leds_d        = leds_q;
        p1_score_d    = p1_score_q;
        p2_score_d    = p2_score_q;
        round_valid_d = 1'b0;
        case (state_q)
            WAIT_PRESS: begin
                if (btn_press) begin
                    p1_move_d = move_t'(player1);
                    p2_move_d = move_t'(player2);
                    state_d   = JUDGE;
                end
            end
            JUDGE: begin
                round_valid_d = 1'b1;
                case (judge(p1_move_q, p2_move_q))
                    P1_WIN: begin
                        leds_d = LED_P1;
                        if (p1_score_q != WIN_SC) p1_score_d = p1_score_q + SW'(1);
                    end
                    P2_WIN: begin
                        leds_d = LED_P2;
                        if (p2_score_q != WIN_SC) p2_score_d = p2_score_q + SW'(1);
                    end
                    DRAW:    leds_d = LED_DRAW;
                    default: leds_d = LED_BAD;
                endcase
                if (p1_score_d == WIN_SC || p2_score_d == WIN_SC) begin
                    state_d = MATCH_DONE;
                end else begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!btn_level) state_d = WAIT_PRESS;
            end
            MATCH_DONE: begin
                leds_d = (p1_score_q == WIN_SC) ? LED_P1 : LED_P2;
                // This press only restarts the match; it never plays a round.
                if (btn_press) begin
                    p1_score_d = '0;
                    p2_score_d = '0;
                    leds_d     = LED_OFF;
                    state_d    = WAIT_PRESS;
                end
            end
            default: state_d = WAIT_PRESS;
        endcase
    end

    // State registers, cleared asynchronously so a reset mid-round discards it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_PRESS;
            p1_move_q     <= STONE;
            p2_move_q     <= STONE;
            leds_q        <= LED_OFF;
            p1_score_q    <= '0;
            p2_score_q    <= '0;
            round_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_move_q     <= p1_move_d;
            p2_move_q     <= p2_move_d;
            leds_q        <= leds_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            round_valid_q <= round_valid_d;
        end
    end

    assign leds        = leds_q;
    assign p1_score    = p1_score_q;
    assign p2_score    = p2_score_q;
    assign round_valid = round_valid_q;
    assign match_over  = (state_q == MATCH_DONE);

endmodule
